time_surface_scanner: RTL

//   Read-side master for the time-surface encoder's read port. On a start pulse it sweeps all GRID_SIZE^2 cells.
//   It drives read_enable/read_addr and realigns the fixed 2-cycle read_value return.
//   It streams (addr, value) over a valid/ready interface to the classifier front end, and reports sum and active-cell count per frame.

---
 rtl/time_surface_scanner.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/time_surface_scanner.sv
// Read-side sweep master for the time-surface encoder: issues credit-limited reads, realigns the
// 2-cycle return into a small FIFO and streams (addr, value) beats. Optional macro: TSS_THRESHOLD_EN.
module time_surface_scanner #(
    parameter int GRID_SIZE  = 16,
    parameter int ADDR_BITS  = 8,
    parameter int VALUE_BITS = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int THRESH     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          read_enable,
    output logic [ADDR_BITS-1:0]          read_addr,
    input  logic [VALUE_BITS-1:0]         read_value,
    output logic                          feat_valid,
    input  logic                          feat_ready,
    output logic [ADDR_BITS-1:0]          feat_addr,
    output logic [VALUE_BITS-1:0]         feat_value,
    output logic                          feat_last,
    output logic [ADDR_BITS+VALUE_BITS-1:0] frame_sum,
    output logic [ADDR_BITS:0]            active_count
);
    localparam int NCELLS = GRID_SIZE * GRID_SIZE;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W  = CNT_W + 2;
    localparam int SUM_W  = ADDR_BITS + VALUE_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NCELLS - 1);

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        THRESH < 0 || THRESH >= (1 << VALUE_BITS)) begin : g_bad_params
        $error("time_surface_scanner: illegal FIFO_DEPTH or THRESH");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                  state_q;
    logic                    busy_q, done_q, re_q;
    logic [ADDR_BITS-1:0]    addr_q;
    logic [SUM_W-1:0]        sum_q;
    logic [ADDR_BITS:0]      count_q;
    logic                    s1_vld_q, s2_vld_q;
    logic [ADDR_BITS-1:0]    s1_addr_q, s2_addr_q;
    logic [ADDR_BITS-1:0]    mem_addr_q [FIFO_DEPTH];
    logic [VALUE_BITS-1:0]   mem_val_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic                    push, pop, can_issue, drained, beat_active;
    logic [OCC_W-1:0]        occupancy;
    logic [VALUE_BITS-1:0]   push_val;

    assign push       = s2_vld_q;
    assign feat_valid = (fifo_cnt_q != '0);
    assign pop        = feat_valid & feat_ready;
    assign feat_addr  = mem_addr_q[rd_ptr_q];
    assign feat_value = mem_val_q[rd_ptr_q];
    assign feat_last  = feat_valid && (feat_addr == LAST_ADDR);

`ifdef TSS_THRESHOLD_EN
    assign push_val    = (read_value >= VALUE_BITS'(THRESH)) ? read_value : '0;
    assign beat_active = (feat_value >= VALUE_BITS'(THRESH));
`else
    assign push_val    = read_value;
    assign beat_active = (feat_value != '0);
`endif

    // Every read in the pipe already owns a FIFO slot; a pop this cycle frees one in time for the next issue.
    assign occupancy = OCC_W'(fifo_cnt_q) + OCC_W'(re_q) + OCC_W'(s1_vld_q) + OCC_W'(s2_vld_q)
                     - OCC_W'(pop);
    assign can_issue = (occupancy < OCC_W'(FIFO_DEPTH));
    assign drained   = (fifo_cnt_q == '0) && !re_q && !s1_vld_q && !s2_vld_q;

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop)
            fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        else if (!push && pop)
            fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            re_q    <= 1'b0;
            addr_q  <= '0;
            sum_q   <= '0;
            count_q <= '0;
        end else begin
            done_q <= 1'b0;
            re_q   <= 1'b0;
            if (pop)
                sum_q <= sum_q + SUM_W'(feat_value);
            if (pop && beat_active)
                count_q <= count_q + {{ADDR_BITS{1'b0}}, 1'b1};
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                        re_q    <= 1'b1;
                        addr_q  <= '0;
                        sum_q   <= '0;
                        count_q <= '0;
                    end
                end
                SCAN: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q <= DRAIN;
                    end else if (can_issue) begin
                        re_q   <= 1'b1;
                        addr_q <= addr_q + ADDR_BITS'(1);
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Two-stage tag pipe lines the issued address up with the encoder's late read_value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s1_addr_q  <= '0;
            s2_addr_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_val_q[i]  <= '0;
            end
        end else begin
            s1_vld_q   <= re_q;
            s1_addr_q  <= addr_q;
            s2_vld_q   <= s1_vld_q;
            s2_addr_q  <= s1_addr_q;
            fifo_cnt_q <= fifo_cnt_d;
            if (push) begin
                mem_addr_q[wr_ptr_q] <= s2_addr_q;
                mem_val_q[wr_ptr_q]  <= push_val;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign read_enable  = re_q;
    assign read_addr    = addr_q;
    assign frame_sum    = sum_q;
    assign active_count = count_q;

endmodule
